polar_rr_sched: RTL and testbench

- Round-robin scheduler that shares one iterative rectangular-to-polar engine (topolar_fsm) between NUM_CH FFT post-process requesters.
- Accepts one (x, y) pair at a time and issues it to the engine. Waits for the engine result, then returns mag/phase tagged with the source channel.
- Includes a watchdog so a hung engine cannot stall the postprocess chain.

---
 rtl/polar_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/polar_rr_sched.sv | 172 +++++++++++++++++
 tb/tb_polar_rr_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_sched_pkg.sv
// Shared types and helpers for the polar_rr_sched round-robin scheduler.
// Holds the FSM state encoding, default parameter values and the channel
// index width helper used for o_ch and the round-robin pointer.
package polar_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

    // A single channel still needs a one-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant search.
// Ports:
//   i_req   - per-channel request vector
//   i_ptr   - channel with highest priority this round
//   o_grant - one-hot grant (first set request at or after i_ptr, wrapping)
//   o_idx   - binary index of the granted channel
//   o_any   - at least one request is set
module rr_arbiter
    import polar_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);

    always_comb begin
        int k;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = (int'(i_ptr) + i) % NUM_CH;
            if (!o_any && i_req[k]) begin
                o_any      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = CH_W'(k);
            end
        end
    end

endmodule

// File: rtl/polar_rr_sched.sv
// Round-robin scheduler sharing one iterative rectangular-to-polar engine
// between NUM_CH requesters, with a watchdog that aborts hung jobs.
//
//   state | meaning
//   IDLE  | waiting for engine idle and a request; grant is combinational
//   ISSUE | eng_vld pulse with latched x/y; watchdog cleared
//   WAIT  | engine busy; capture result on eng_ovld or abort on timeout
//
// Ports:
//   clk, arstn              - clock, async active-low reset
//   req_vld/req_x/req_y     - per-channel requests (flattened DATA_W slices)
//   req_rdy                 - one-hot accept
//   eng_vld/eng_x/eng_y     - start pulse and operands to the engine
//   eng_ready/eng_ovld      - engine idle / result valid
//   eng_mag/eng_phase       - engine result
//   o_vld/o_ch/o_mag/o_phase- tagged result, o_vld is a one-cycle pulse
//   o_err                   - one-cycle pulse when a job times out
module polar_rr_sched
    import polar_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       arstn,
    input  logic [NUM_CH-1:0]          req_vld,
    input  logic [NUM_CH*DATA_W-1:0]   req_x,
    input  logic [NUM_CH*DATA_W-1:0]   req_y,
    output logic [NUM_CH-1:0]          req_rdy,
    output logic                       eng_vld,
    output logic [DATA_W-1:0]          eng_x,
    output logic [DATA_W-1:0]          eng_y,
    input  logic                       eng_ready,
    input  logic                       eng_ovld,
    input  logic [DATA_W-1:0]          eng_mag,
    input  logic [DATA_W-1:0]          eng_phase,
    output logic                       o_vld,
    output logic [ch_w(NUM_CH)-1:0]    o_ch,
    output logic [DATA_W-1:0]          o_mag,
    output logic [DATA_W-1:0]          o_phase,
    output logic                       o_err
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     r_ch;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_eng_x;
    logic [DATA_W-1:0]   r_eng_y;
    logic                r_o_vld;
    logic                r_o_err;
    logic [CH_W-1:0]     r_o_ch;
    logic [DATA_W-1:0]   r_o_mag;
    logic [DATA_W-1:0]   r_o_phase;

    logic [NUM_CH-1:0]   w_grant;
    logic [CH_W-1:0]     w_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_sel_x;
    logic [DATA_W-1:0]   w_sel_y;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .i_req   (req_vld),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_x = req_x[int'(w_idx)*DATA_W +: DATA_W];
    assign w_sel_y = req_y[int'(w_idx)*DATA_W +: DATA_W];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
        req_rdy     = '0;
        eng_vld     = 1'b0;
        case (r_state)
            IDLE: begin
                // The grant only ever lands on a valid channel, so a grant is an accept.
                if (eng_ready && w_any) begin
                    req_rdy     = w_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                eng_vld     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_ovld || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_ptr     <= '0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_eng_x   <= '0;
            r_eng_y   <= '0;
            r_o_vld   <= 1'b0;
            r_o_err   <= 1'b0;
            r_o_ch    <= '0;
            r_o_mag   <= '0;
            r_o_phase <= '0;
        end else begin
            r_o_vld <= 1'b0;
            r_o_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_eng_x <= w_sel_x;
                        r_eng_y <= w_sel_y;
                        r_ch    <= w_idx;
                        r_ptr   <= (int'(w_idx) == NUM_CH - 1) ? '0 : w_idx + CH_W'(1);
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A result arriving on the timeout cycle still counts as a result.
                    if (eng_ovld) begin
                        r_o_vld   <= 1'b1;
                        r_o_ch    <= r_ch;
                        r_o_mag   <= eng_mag;
                        r_o_phase <= eng_phase;
                    end else if (w_timeout) begin
                        r_o_err <= 1'b1;
                        r_o_ch  <= r_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_x   = r_eng_x;
    assign eng_y   = r_eng_y;
    assign o_vld   = r_o_vld;
    assign o_err   = r_o_err;
    assign o_ch    = r_o_ch;
    assign o_mag   = r_o_mag;
    assign o_phase = r_o_phase;

endmodule

// File: tb/tb_polar_rr_sched.sv
// Scoreboard bench for polar_rr_sched with a fixed-latency stub engine
// (mag = x + y, phase = x - y). Requests are recorded at grant time and
// the expected result is queued; a monitor on the falling edge compares
// every engine start pulse and every o_vld / o_err pulse.
module tb_polar_rr_sched;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 18;

    logic                     clk = 1'b0;
    logic                     arstn;
    logic [NUM_CH-1:0]        req_vld;
    logic [NUM_CH*DATA_W-1:0] req_x;
    logic [NUM_CH*DATA_W-1:0] req_y;
    logic [NUM_CH-1:0]        req_rdy;
    logic                     eng_vld;
    logic [DATA_W-1:0]        eng_x;
    logic [DATA_W-1:0]        eng_y;
    logic                     eng_ready;
    logic                     eng_ovld;
    logic [DATA_W-1:0]        eng_mag;
    logic [DATA_W-1:0]        eng_phase;
    logic                     o_vld;
    logic [1:0]               o_ch;
    logic [DATA_W-1:0]        o_mag;
    logic [DATA_W-1:0]        o_phase;
    logic                     o_err;

    polar_rr_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .req_vld   (req_vld),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_rdy   (req_rdy),
        .eng_vld   (eng_vld),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_ready (eng_ready),
        .eng_ovld  (eng_ovld),
        .eng_mag   (eng_mag),
        .eng_phase (eng_phase),
        .o_vld     (o_vld),
        .o_ch      (o_ch),
        .o_mag     (o_mag),
        .o_phase   (o_phase),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    // ---------------- stub engine ----------------
    bit          hang;
    bit          block_rdy;
    logic        s_busy;
    int          s_cnt;
    logic [31:0] s_mag;
    logic [31:0] s_ph;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s_busy <= 1'b0;
            s_cnt  <= 0;
            s_mag  <= '0;
            s_ph   <= '0;
        end else if (s_busy) begin
            if (s_cnt == 0) s_busy <= 1'b0;
            else            s_cnt  <= s_cnt - 1;
        end else if (eng_vld && !hang) begin
            s_busy <= 1'b1;
            s_cnt  <= LAT - 1;
            s_mag  <= eng_x + eng_y;
            s_ph   <= eng_x - eng_y;
        end
    end

    assign eng_ready = !s_busy && !block_rdy;
    assign eng_ovld  = s_busy && (s_cnt == 0);
    assign eng_mag   = eng_ovld ? s_mag : 32'hDEAD_BEEF;
    assign eng_phase = eng_ovld ? s_ph  : 32'h5A5A_5A5A;

    // ---------------- bookkeeping ----------------
    typedef struct { int cyc; logic [31:0] x; logic [31:0] y; } eng_t;
    typedef struct { int cyc; bit err; int ch; logic [31:0] mag; logic [31:0] ph; } res_t;

    eng_t        engq[$];
    res_t        sbq[$];
    int          glog[$];
    int          rlog[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_errp = 0;
    int          n_acc = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          last_acc = 0;
    bit          outstanding = 0;
    bit          sticky = 0;
    logic [3:0]  acc_mask = '0;
    int          last_ch = 0;
    logic [31:0] last_mag = '0;
    logic [31:0] last_ph = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic failn(input string nm, input string what);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endtask

    // First active channel at or after the pointer, wrapping.
    function automatic logic [3:0] model_grant(input logic [3:0] v, input int p);
        for (int n = 0; n < NUM_CH; n++) begin
            if (v[(p + n) % NUM_CH]) return 4'(1 << ((p + n) % NUM_CH));
        end
        return '0;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int k = 0; k < NUM_CH; k++) if (v[k]) return k;
        return 0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [3:0] eg;
        int         g;
        eng_t       e;
        res_t       r;
        res_t       nr;
        eng_t       ne;
        if (!arstn) begin
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_eng_vld", eng_vld, 0);
            chk("rst_o_vld", o_vld, 0);
            chk("rst_o_err", o_err, 0);
            sbq.delete();
            engq.delete();
            outstanding = 0;
            m_ptr       = 0;
            acc_mask    = '0;
            last_ch     = 0;
            last_mag    = '0;
            last_ph     = '0;
        end else begin
            while (engq.size() > 0 && engq[0].cyc < cyc) begin
                failn("eng_vld_missing", "no start pulse, expected one");
                void'(engq.pop_front());
            end
            if (eng_vld) begin
                if (engq.size() == 0) failn("eng_vld_unexpected", "start pulse seen, expected none");
                else begin
                    e = engq.pop_front();
                    chk("eng_vld_cycle", cyc, e.cyc);
                    chk("eng_x", eng_x, e.x);
                    chk("eng_y", eng_y, e.y);
                end
            end
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                failn("result_missing", "no o_vld/o_err pulse, expected one");
                void'(sbq.pop_front());
                outstanding = 0;
            end
            if (o_vld || o_err) begin
                chk("vld_err_exclusive", o_vld && o_err, 0);
                if (sbq.size() == 0) failn("result_unexpected", "output pulse seen, expected none");
                else begin
                    r = sbq.pop_front();
                    outstanding = 0;
                    chk("result_cycle", cyc, r.cyc);
                    chk("result_is_err", o_err, r.err);
                    chk("o_ch", o_ch, r.ch);
                    if (r.err) begin
                        n_errp++;
                        chk("err_mag_held", o_mag, last_mag);
                        chk("err_phase_held", o_phase, last_ph);
                    end else begin
                        chk("o_mag", o_mag, r.mag);
                        chk("o_phase", o_phase, r.ph);
                        last_mag = r.mag;
                        last_ph  = r.ph;
                        rlog.push_back(r.ch);
                    end
                    last_ch = r.ch;
                end
            end else begin
                chk("hold_o_ch", o_ch, last_ch);
                chk("hold_o_mag", o_mag, last_mag);
                chk("hold_o_phase", o_phase, last_ph);
            end
            eg = (!outstanding && eng_ready) ? model_grant(req_vld, m_ptr) : 4'b0;
            chk("req_rdy", req_rdy, eg);
            if (eg != 0) begin
                g      = onehot_idx(eg);
                ne.cyc = cyc + 1;
                ne.x   = req_x[g*DATA_W +: DATA_W];
                ne.y   = req_y[g*DATA_W +: DATA_W];
                engq.push_back(ne);
                nr.err = hang;
                nr.ch  = g;
                nr.mag = ne.x + ne.y;
                nr.ph  = ne.x - ne.y;
                nr.cyc = hang ? cyc + 1 + TIMEOUT + 1 : cyc + 1 + LAT + 1;
                sbq.push_back(nr);
                m_ptr       = (g + 1) % NUM_CH;
                outstanding = 1;
                acc_mask    = eg;
                last_acc    = cyc;
                n_acc++;
                glog.push_back(g);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int k, input logic [31:0] x, input logic [31:0] y);
        req_vld[k]                 = 1'b1;
        req_x[k*DATA_W +: DATA_W]  = x;
        req_y[k*DATA_W +: DATA_W]  = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!sticky) req_vld = req_vld & ~acc_mask;
        acc_mask = '0;
    endtask

    task automatic wait_grants(input int n, input int budget, input string nm);
        int i = 0;
        while (glog.size() < n && i < budget) begin
            step();
            i++;
        end
        chk({nm, "_in_budget"}, (glog.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i = 0;
        while ((req_vld != 0 || outstanding || sbq.size() != 0 || engq.size() != 0) && i < budget) begin
            step();
            i++;
        end
        chk({nm, "_in_budget"}, (i < budget), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int fair_exp[5];
        int sparse_exp[3];
        int errp0;
        int target;
        int guard;
        fair_exp   = '{0, 1, 2, 3, 0};
        sparse_exp = '{1, 3, 1};

        arstn = 1'b1; req_vld = '0; req_x = '0; req_y = '0;
        hang = 0; block_rdy = 0; sticky = 0;
        #2 arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        repeat (3) step();
        chk("rst_idle_req_rdy", req_rdy, 0);
        chk("rst_idle_eng_vld", eng_vld, 0);
        chk("rst_idle_eng_x", eng_x, 0);
        chk("rst_idle_eng_y", eng_y, 0);
        chk("rst_idle_o_vld", o_vld, 0);
        chk("rst_idle_o_err", o_err, 0);
        chk("rst_idle_o_ch", o_ch, 0);
        chk("rst_idle_o_mag", o_mag, 0);
        chk("rst_idle_o_phase", o_phase, 0);

        // fairness: all channels held valid
        glog.delete(); rlog.delete(); errp0 = n_errp;
        sticky = 1;
        for (int k = 0; k < NUM_CH; k++) set_req(k, (k + 1) << 10, 1 << 10);
        wait_grants(5, 200, "fair_grants");
        req_vld = '0; sticky = 0;
        wait_idle(100, "fair_drain");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair_grant%0d", i), glog[i], fair_exp[i]);
            chk($sformatf("fair_result_ch%0d", i), rlog[i], fair_exp[i]);
        end
        chk("fair_no_err", n_errp - errp0, 0);

        // sparse: channels 1 and 3
        glog.delete(); rlog.delete();
        sticky = 1;
        set_req(1, -5 << 10, -1 << 10);
        set_req(3, -5 << 10, -1 << 10);
        wait_grants(3, 100, "sparse_grants");
        req_vld = '0; sticky = 0;
        wait_idle(100, "sparse_drain");
        for (int i = 0; i < 3; i++) chk($sformatf("sparse_grant%0d", i), glog[i], sparse_exp[i]);
        chk("sparse_mag", o_mag, 32'hFFFF_E800);
        chk("sparse_phase", o_phase, 32'hFFFF_F000);

        // single request on channel 2
        glog.delete();
        set_req(2, 1 << 10, 1 << 10);
        wait_idle(60, "single");
        chk("single_grant", glog[0], 2);
        chk("single_o_ch", o_ch, 2);
        chk("single_o_mag", o_mag, 2048);
        chk("single_o_phase", o_phase, 0);

        // engine not ready: no grant, pointer unchanged
        glog.delete();
        block_rdy = 1;
        set_req(0, 32'h11, 32'h22);
        set_req(1, 32'h33, 32'h44);
        repeat (5) step();
        chk("blocked_no_grant", glog.size(), 0);
        block_rdy = 0;
        wait_idle(100, "blocked_release");
        chk("blocked_first_grant", glog[0], 0);
        chk("blocked_second_grant", glog[1], 1);

        // timeout: engine never answers
        glog.delete(); errp0 = n_errp;
        hang = 1;
        set_req(3, 32'h100, 32'h7);
        wait_idle(200, "timeout");
        hang = 0;
        chk("timeout_err_pulses", n_errp - errp0, 1);
        set_req(1, 32'h40, 32'h4);
        wait_idle(60, "after_timeout");
        chk("after_timeout_grant", glog[1], 1);

        // reset five cycles into WAIT
        glog.delete();
        set_req(2, 32'h1234, 32'h0234);
        wait_grants(1, 50, "midrst_grant");
        guard = 0;
        while (cyc < last_acc + 7 && guard < 20) begin
            step();
            guard++;
        end
        arstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        req_vld = '0;
        glog.delete();
        repeat (10) step();
        set_req(0, 32'h0500, 32'h0100);
        set_req(3, 32'h0600, 32'h0200);
        wait_idle(100, "post_reset");
        chk("post_reset_first_grant", glog[0], 0);
        chk("post_reset_second_grant", glog[1], 3);

        // randomized traffic
        target = n_acc + 40;
        guard  = 0;
        while (n_acc < target && guard < 3000) begin
            step();
            guard++;
            block_rdy = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < NUM_CH; k++) begin
                if (!req_vld[k] && $urandom_range(0, 3) == 0 && (n_acc + $countones(req_vld)) < target)
                    set_req(k, $urandom, $urandom);
            end
        end
        block_rdy = 0;
        chk("random_in_budget", (guard < 3000), 1);
        wait_idle(200, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1, "global timeout");
    end

endmodule
